// File: rtl/bits_to_bytes_packer.sv
// ============================================================================
// Module   : bits_to_bytes_packer
// Purpose  : Packs an LSB-first serial bit stream into bytes. Each byte goes out
//            on a byte stream and is also kept in a parallel byte array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bits_to_bytes_packer #(
    parameter int MAX_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             len,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_last,
    output logic [8*MAX_BYTES-1:0] out_bytes,
    output logic                   busy,
    output logic                   done
);

    localparam logic [7:0] c_MAX_LEN = 8'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_len_eff;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte_idx;
    logic [7:0] r_byte_out;
    logic       r_byte_last;
    logic [7:0] r_mem [MAX_BYTES];

    logic [7:0] w_len_eff;
    logic       w_start_acc;
    logic       w_bit_acc;
    logic       w_byte_hs;

    assign w_len_eff   = (len > c_MAX_LEN) ? c_MAX_LEN : len;
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_bit_acc   = (r_state == S_COLLECT) && bit_valid;
    assign w_byte_hs   = (r_state == S_EMIT) && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_len_eff == 8'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bit_valid && (r_bit_cnt == 3'd7)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (byte_ready) begin
                    w_state_nxt = r_byte_last ? S_DONE : S_COLLECT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_eff   <= 8'd0;
            r_shift     <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_byte_idx  <= 8'd0;
            r_byte_out  <= 8'd0;
            r_byte_last <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            if (w_start_acc) begin
                r_len_eff  <= w_len_eff;
                r_shift    <= 8'd0;
                r_bit_cnt  <= 3'd0;
                r_byte_idx <= 8'd0;
                for (int i = 0; i < MAX_BYTES; i++) begin
                    r_mem[i] <= 8'd0;
                end
            end

            if (w_bit_acc) begin
                r_shift[r_bit_cnt] <= bit_in;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
                // The 8th bit bypasses the shift register straight into the byte.
                if (r_bit_cnt == 3'd7) begin
                    r_byte_out  <= {bit_in, r_shift[6:0]};
                    r_byte_last <= (r_byte_idx == (r_len_eff - 8'd1));
                end
            end

            if (w_byte_hs) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (r_byte_idx == 8'(i)) begin
                        r_mem[i] <= r_byte_out;
                    end
                end
                if (!r_byte_last) begin
                    r_byte_idx <= r_byte_idx + 8'd1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_out_bytes
            assign out_bytes[8*gi +: 8] = r_mem[gi];
        end
    endgenerate

    assign bit_ready  = (r_state == S_COLLECT);
    assign byte_valid = (r_state == S_EMIT);
    assign byte_out   = r_byte_out;
    assign byte_last  = r_byte_last;
    assign busy       = (r_state == S_COLLECT) || (r_state == S_EMIT);
    assign done       = (r_state == S_DONE);

endmodule

`default_nettype wire
